// File: rtl/rtc_bus_writer.sv
// Write-side master for the RTC multiplexed address/data bus: one request becomes
// an address phase, a CS# gap and a data phase, with every pad output registered.
module rtc_bus_writer #(
  parameter int N       = 8,
  parameter int T_SETUP = 2,
  parameter int T_PULSE = 4,
  parameter int T_HOLD  = 2,
  parameter int T_GAP   = 3,
  parameter int CW      = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] addr,
  input  logic [N-1:0] data,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] ad_out,
  output logic         ad_oe,
  output logic         cs_n,
  output logic         ad_n,
  output logic         wr_n,
  output logic         rd_n
);

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    ADDR_SETUP = 4'd1,
    ADDR_WR    = 4'd2,
    ADDR_HOLD  = 4'd3,
    GAP        = 4'd4,
    DATA_SETUP = 4'd5,
    DATA_WR    = 4'd6,
    DATA_HOLD  = 4'd7,
    DONE       = 4'd8
  } state_t;

  localparam logic [CW-1:0] LD_SETUP = CW'(T_SETUP - 1);
  localparam logic [CW-1:0] LD_PULSE = CW'(T_PULSE - 1);
  localparam logic [CW-1:0] LD_HOLD  = CW'(T_HOLD - 1);
  localparam logic [CW-1:0] LD_GAP   = CW'(T_GAP - 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  addr_lat_q, addr_lat_d;
  logic [N-1:0]  data_lat_q, data_lat_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [N-1:0]  ad_out_q, ad_out_d;
  logic          ad_oe_q, ad_oe_d;
  logic          cs_n_q, cs_n_d;
  logic          ad_n_q, ad_n_d;
  logic          wr_n_q, wr_n_d;
  logic          rd_n_q, rd_n_d;
  logic          cnt_last_s;

  assign cnt_last_s = (cnt_q == CNT_ZERO);

  // Next state, timing counter and request latches.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_lat_d = addr_lat_q;
    data_lat_d = data_lat_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = ADDR_SETUP;
          cnt_d      = LD_SETUP;
          addr_lat_d = addr;
          data_lat_d = data;
        end else begin
          cnt_d = CNT_ZERO;
        end
      end
      ADDR_SETUP: begin
        if (cnt_last_s) begin
          state_d = ADDR_WR;
          cnt_d   = LD_PULSE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ADDR_WR: begin
        if (cnt_last_s) begin
          state_d = ADDR_HOLD;
          cnt_d   = LD_HOLD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ADDR_HOLD: begin
        if (cnt_last_s) begin
          state_d = GAP;
          cnt_d   = LD_GAP;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      GAP: begin
        if (cnt_last_s) begin
          state_d = DATA_SETUP;
          cnt_d   = LD_SETUP;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      DATA_SETUP: begin
        if (cnt_last_s) begin
          state_d = DATA_WR;
          cnt_d   = LD_PULSE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      DATA_WR: begin
        if (cnt_last_s) begin
          state_d = DATA_HOLD;
          cnt_d   = LD_HOLD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      DATA_HOLD: begin
        if (cnt_last_s) begin
          state_d = DONE;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = CNT_ZERO;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // Pad values are decoded from the state being entered so they flop in step with it.
  always_comb begin
    busy_d   = 1'b1;
    done_d   = 1'b0;
    ad_out_d = ad_out_q;
    ad_oe_d  = ad_oe_q;
    cs_n_d   = cs_n_q;
    ad_n_d   = ad_n_q;
    wr_n_d   = 1'b1;
    rd_n_d   = 1'b1;
    case (state_d)
      IDLE: begin
        busy_d   = 1'b0;
        ad_out_d = {N{1'b0}};
        ad_oe_d  = 1'b0;
        cs_n_d   = 1'b1;
        ad_n_d   = 1'b1;
      end
      ADDR_SETUP, ADDR_WR, ADDR_HOLD: begin
        ad_out_d = addr_lat_d;
        ad_oe_d  = 1'b1;
        cs_n_d   = 1'b0;
        ad_n_d   = 1'b0;
        wr_n_d   = (state_d != ADDR_WR);
      end
      GAP: begin
        ad_oe_d = 1'b0;
        cs_n_d  = 1'b1;
      end
      DATA_SETUP, DATA_WR, DATA_HOLD: begin
        ad_out_d = data_lat_d;
        ad_oe_d  = 1'b1;
        cs_n_d   = 1'b0;
        ad_n_d   = 1'b1;
        wr_n_d   = (state_d != DATA_WR);
      end
      DONE: begin
        done_d  = 1'b1;
        ad_oe_d = 1'b0;
        cs_n_d  = 1'b1;
        ad_n_d  = 1'b1;
      end
      default: begin
        busy_d   = 1'b0;
        ad_out_d = {N{1'b0}};
        ad_oe_d  = 1'b0;
        cs_n_d   = 1'b1;
        ad_n_d   = 1'b1;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= CNT_ZERO;
      addr_lat_q <= {N{1'b0}};
      data_lat_q <= {N{1'b0}};
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ad_out_q   <= {N{1'b0}};
      ad_oe_q    <= 1'b0;
      cs_n_q     <= 1'b1;
      ad_n_q     <= 1'b1;
      wr_n_q     <= 1'b1;
      rd_n_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_lat_q <= addr_lat_d;
      data_lat_q <= data_lat_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ad_out_q   <= ad_out_d;
      ad_oe_q    <= ad_oe_d;
      cs_n_q     <= cs_n_d;
      ad_n_q     <= ad_n_d;
      wr_n_q     <= wr_n_d;
      rd_n_q     <= rd_n_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign ad_out = ad_out_q;
  assign ad_oe  = ad_oe_q;
  assign cs_n   = cs_n_q;
  assign ad_n   = ad_n_q;
  assign wr_n   = wr_n_q;
  assign rd_n   = rd_n_q;

endmodule
